// File: rtl/signature_motion_detector.sv
// Hamming-distance motion detector on successive 128-bit dHash frame signatures.
// Multi-cycle popcount FSM with custom-instruction access to results, counters and threshold.
module signature_motion_detector #(
  parameter logic [7:0]  customId          = 8'd0,
  parameter int unsigned BITS_PER_CYCLE    = 16,
  parameter logic [7:0]  DEFAULT_THRESHOLD = 8'd10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] signatureIn,
  input  logic         signatureValid,
  input  logic         ciStart,
  input  logic [7:0]   ciN,
  input  logic [31:0]  ciValueA,
  input  logic [31:0]  ciValueB,
  output logic [31:0]  ciResult,
  output logic         ciDone,
  output logic         motionIrq
);

  localparam int unsigned NCHUNK = 128 / BITS_PER_CYCLE;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  state_t        state;
  logic [127:0]  prevSig;
  logic [127:0]  curSig;
  logic [127:0]  xorSig;
  logic          prevValid;
  logic [7:0]    acc;
  logic [CW-1:0] chunkIdx;
  logic [7:0]    distance;
  logic          motion;
  logic [15:0]   frameCount;
  logic [15:0]   motionCount;
  logic [7:0]    overrun;
  logic [7:0]    threshold;

  logic                      ciSel;
  logic [2:0]                op;
  logic                      busy;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic                      motionHit;
  logic                      unusedCiBits;

  assign ciSel        = ciStart && (ciN == customId);
  assign ciDone       = ciSel;
  assign op           = ciValueA[2:0];
  assign busy         = (state != IDLE);
  assign motionHit    = (acc >= threshold);
  assign unusedCiBits = ^{ciValueA[31:3], ciValueB[31:8]};

  function automatic logic [7:0] popcount(input logic [BITS_PER_CYCLE-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  always_comb begin
    int unsigned base;
    base  = 32'(chunkIdx) * BITS_PER_CYCLE;
    chunk = xorSig[base +: BITS_PER_CYCLE];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prevSig     <= '0;
      curSig      <= '0;
      xorSig      <= '0;
      prevValid   <= 1'b0;
      acc         <= '0;
      chunkIdx    <= '0;
      distance    <= '0;
      motion      <= 1'b0;
      frameCount  <= '0;
      motionCount <= '0;
      overrun     <= '0;
      threshold   <= DEFAULT_THRESHOLD;
      motionIrq   <= 1'b0;
    end else begin
      motionIrq <= 1'b0;
      case (state)
        IDLE: begin
          if (signatureValid) begin
            curSig   <= signatureIn;
            xorSig   <= signatureIn ^ prevSig;
            acc      <= '0;
            chunkIdx <= '0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          acc      <= acc + popcount(chunk);
          chunkIdx <= chunkIdx + 1'b1;
          if (chunkIdx == CW'(NCHUNK - 1)) state <= COMMIT;
        end
        COMMIT: begin
          prevSig    <= curSig;
          prevValid  <= 1'b1;
          frameCount <= frameCount + 16'd1;
          if (prevValid) begin
            distance <= acc;
            motion   <= motionHit;
            if (motionHit) begin
              motionIrq <= 1'b1;
              if (motionCount != '1) motionCount <= motionCount + 16'd1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (signatureValid && busy && (overrun != '1)) overrun <= overrun + 8'd1;

      if (ciSel && (op == 3'd4)) threshold <= ciValueB[7:0];

      // Placed last so a clear on the same edge as a commit or overrun wins.
      if (ciSel && (op == 3'd5)) begin
        motionCount <= '0;
        overrun     <= '0;
        frameCount  <= '0;
      end
    end
  end

  always_comb begin
    ciResult = '0;
    if (ciSel) begin
      case (op)
        3'd0:    ciResult = {24'b0, distance};
        3'd1:    ciResult = {motionCount, overrun, 5'b0, busy, prevValid, motion};
        3'd2:    ciResult = {16'b0, frameCount};
        3'd3:    ciResult = {24'b0, threshold};
        3'd4:    ciResult = {24'b0, threshold};
        default: ciResult = '0;
      endcase
    end
  end

endmodule
